// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: 3-stage pipelined 3x3 Sobel edge detector on RGB444 windows.
// Stage p0 registers per-pixel gray, p1 registers Gx/Gy, and the output stage
// registers the edge pixel plus the per-frame edge counter.
// Optional macro SOBEL_BINARY_EN: when defined, edge_data is 12'hFFF/12'h000
// (binary); when undefined, edge_data is the graded {n,n,n} with n = mag_sat[7:4].
module sobel_edge_filter #(
    parameter logic [7:0] THRESHOLD = 8'd100,
    parameter logic [9:0] H_LAST    = 10'd639,
    parameter logic [9:0] V_LAST    = 10'd479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de_in,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    input  logic [11:0] PixelData_00,
    input  logic [11:0] PixelData_01,
    input  logic [11:0] PixelData_02,
    input  logic [11:0] PixelData_10,
    input  logic [11:0] PixelData_11,
    input  logic [11:0] PixelData_12,
    input  logic [11:0] PixelData_20,
    input  logic [11:0] PixelData_21,
    input  logic [11:0] PixelData_22,
    output logic        de_out,
    output logic [9:0]  x_out,
    output logic [9:0]  y_out,
    output logic [11:0] edge_data,
    output logic [18:0] edge_count,
    output logic        count_valid
);

    localparam logic [18:0] ACC_MAX = '1;

    // g = R + 2G + B, range 0..60
    function automatic logic [5:0] gray(input logic [11:0] p);
        return {2'b00, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b00, p[3:0]};
    endfunction

    // a + 2b + c of gray values, max 240 so the MSB is always zero
    function automatic logic [8:0] wsum(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [8:0] abs9(input logic signed [8:0] v);
        return v[8] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [7:0] sat8(input logic [9:0] m);
        return (m > 10'd255) ? 8'hFF : m[7:0];
    endfunction

    // Accumulator sticks at all-ones instead of wrapping
    function automatic logic [18:0] sat_inc(input logic [18:0] a, input logic inc);
        if (inc && (a != ACC_MAX)) begin
            return a + 19'd1;
        end
        return a;
    endfunction

    // ---- stage p0: gray conversion ----
    logic [11:0] pix [0:8];
    logic [5:0]  g_p0_q [0:8];
    logic        de_p0_q;
    logic [9:0]  x_p0_q, y_p0_q;

    assign pix[0] = PixelData_00;
    assign pix[1] = PixelData_01;
    assign pix[2] = PixelData_02;
    assign pix[3] = PixelData_10;
    assign pix[4] = PixelData_11;
    assign pix[5] = PixelData_12;
    assign pix[6] = PixelData_20;
    assign pix[7] = PixelData_21;
    assign pix[8] = PixelData_22;

    // Register gray of every window pixel alongside de/x/y
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            g_p0_q[i] <= reset ? 6'd0 : gray(pix[i]);
        end
        if (reset) begin
            de_p0_q <= 1'b0;
            x_p0_q  <= '0;
            y_p0_q  <= '0;
        end else begin
            de_p0_q <= de_in;
            x_p0_q  <= x_in;
            y_p0_q  <= y_in;
        end
    end

    // ---- stage p1: gradients ----
    logic signed [8:0] gx_p1_d, gy_p1_d;
    logic signed [8:0] gx_p1_q, gy_p1_q;
    logic              de_p1_q;
    logic [9:0]        x_p1_q, y_p1_q;

    assign gx_p1_d = $signed(wsum(g_p0_q[2], g_p0_q[5], g_p0_q[8]))
                   - $signed(wsum(g_p0_q[0], g_p0_q[3], g_p0_q[6]));
    assign gy_p1_d = $signed(wsum(g_p0_q[6], g_p0_q[7], g_p0_q[8]))
                   - $signed(wsum(g_p0_q[0], g_p0_q[1], g_p0_q[2]));

    // Register Sobel gradients with their de/x/y
    always_ff @(posedge clk) begin
        if (reset) begin
            gx_p1_q <= '0;
            gy_p1_q <= '0;
            de_p1_q <= 1'b0;
            x_p1_q  <= '0;
            y_p1_q  <= '0;
        end else begin
            gx_p1_q <= gx_p1_d;
            gy_p1_q <= gy_p1_d;
            de_p1_q <= de_p1_q_next();
            x_p1_q  <= x_p0_q;
            y_p1_q  <= y_p0_q;
        end
    end

    function automatic logic de_p1_q_next();
        return de_p0_q;
    endfunction

    // ---- stage p2: magnitude, threshold, output and frame count ----
    logic [9:0]  mag_p2_d;
    logic [7:0]  mag_sat_p2_d;
    logic        edge_p2_d;
    logic        frame_end_p2_d;
    logic [11:0] edge_data_p2_d;
    logic [18:0] acc_inc_d;

    logic [11:0] edge_data_q;
    logic        de_out_q;
    logic [9:0]  x_out_q, y_out_q;
    logic [18:0] edge_count_q;
    logic        count_valid_q;
    logic [18:0] acc_q;

    assign mag_p2_d       = {1'b0, abs9(gx_p1_q)} + {1'b0, abs9(gy_p1_q)};
    assign mag_sat_p2_d   = sat8(mag_p2_d);
    assign edge_p2_d      = de_p1_q && (mag_sat_p2_d >= THRESHOLD);
    assign frame_end_p2_d = de_p1_q && (x_p1_q == H_LAST) && (y_p1_q == V_LAST);
    assign acc_inc_d      = sat_inc(acc_q, edge_p2_d);

`ifdef SOBEL_BINARY_EN
    assign edge_data_p2_d = edge_p2_d ? 12'hFFF : 12'h000;
`else
    assign edge_data_p2_d = de_p1_q ? {mag_sat_p2_d[7:4], mag_sat_p2_d[7:4], mag_sat_p2_d[7:4]}
                                    : 12'h000;
`endif

    // Output registers plus frame edge accumulator; frame end folds in its own edge
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_data_q   <= '0;
            de_out_q      <= 1'b0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
            acc_q         <= '0;
        end else begin
            edge_data_q   <= edge_data_p2_d;
            de_out_q      <= de_p1_q;
            x_out_q       <= x_p1_q;
            y_out_q       <= y_p1_q;
            count_valid_q <= frame_end_p2_d;
            if (frame_end_p2_d) begin
                edge_count_q <= acc_inc_d;
                acc_q        <= '0;
            end else begin
                acc_q        <= acc_inc_d;
            end
        end
    end

    assign edge_data   = edge_data_q;
    assign de_out      = de_out_q;
    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign edge_count  = edge_count_q;
    assign count_valid = count_valid_q;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Directed bench for sobel_edge_filter (graded build) on a reduced 8x4 frame.
module tb_sobel_edge_filter;

    localparam int HW = 8;
    localparam int VH = 4;
    localparam int NPIX = HW * VH;

    localparam int K_UNI  = 0;  // all 12'h888, flat
    localparam int K_RCOL = 1;  // right column 12'h111, mag 16
    localparam int K_TRC  = 2;  // top row + right column 12'hFFF, mag 360 -> 255
    localparam int K_M100 = 3;  // right column g=25, mag 100 (edge at threshold)
    localparam int K_M98  = 4;  // right column g=24/25/24, mag 98 (just below)

    logic        clk = 1'b0;
    logic        reset;
    logic        de_in;
    logic [9:0]  x_in, y_in;
    logic [11:0] px [9];
    logic        de_out;
    logic [9:0]  x_out, y_out;
    logic [11:0] edge_data;
    logic [18:0] edge_count;
    logic        count_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = 0;
    int last_cyc = 0;
    int p_before;

    sobel_edge_filter #(
        .THRESHOLD(8'd100),
        .H_LAST   (10'(HW - 1)),
        .V_LAST   (10'(VH - 1))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .de_in       (de_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .PixelData_00(px[0]),
        .PixelData_01(px[1]),
        .PixelData_02(px[2]),
        .PixelData_10(px[3]),
        .PixelData_11(px[4]),
        .PixelData_12(px[5]),
        .PixelData_20(px[6]),
        .PixelData_21(px[7]),
        .PixelData_22(px[8]),
        .de_out      (de_out),
        .x_out       (x_out),
        .y_out       (y_out),
        .edge_data   (edge_data),
        .edge_count  (edge_count),
        .count_valid (count_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (count_valid === 1'b1) begin
            pulses    <= pulses + 1;
            pulse_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic de, input int x, input int y);
        for (int i = 0; i < 9; i++) px[i] = 12'h000;
        case (k)
            K_UNI:  for (int i = 0; i < 9; i++) px[i] = 12'h888;
            K_RCOL: begin px[2] = 12'h111; px[5] = 12'h111; px[8] = 12'h111; end
            K_TRC:  begin
                px[0] = 12'hFFF; px[1] = 12'hFFF; px[2] = 12'hFFF;
                px[5] = 12'hFFF; px[8] = 12'hFFF;
            end
            K_M100: begin px[2] = 12'h55A; px[5] = 12'h55A; px[8] = 12'h55A; end
            K_M98:  begin px[2] = 12'h484; px[5] = 12'h55A; px[8] = 12'h484; end
            default: ;
        endcase
        de_in = de;
        x_in  = 10'(x);
        y_in  = 10'(y);
    endtask

    task automatic idle();
        for (int i = 0; i < 9; i++) px[i] = 12'h000;
        de_in = 1'b0;
        x_in  = '0;
        y_in  = '0;
    endtask

    function automatic int kind_of(input int f, input int i);
        case (f)
            0: begin
                if (i inside {0, 3, 5, 8, 12, 17, 20, 25, 31}) return K_TRC;
                if (i == 28) return K_M100;
                if (i == 10) return K_M98;
                if (i == 14) return K_RCOL;
            end
            1: if (i inside {2, 9, 31}) return K_TRC;
            2: if (i < 6) return K_TRC;
            3: begin
                if (i inside {1, 4, 7, 16, 30}) return K_TRC;
                if (i == 20) return K_M98;
            end
            default: ;
        endcase
        return K_UNI;
    endfunction

    task automatic stream(input int f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(kind_of(f, i), 1'b1, i % HW, i / HW);
            last_cyc = cyc;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            idle();
        end
    endtask

    task automatic test_win(input string tag, input int k, input logic de,
                            input int x, input int y, input logic [11:0] exp_data);
        @(negedge clk);
        drive(k, de, x, y);
        settle(2);
        chk({tag, "_early_de"}, 32'(de_out), 32'd0);
        settle(1);
        chk({tag, "_data"}, 32'(edge_data), 32'(exp_data));
        chk({tag, "_de"},   32'(de_out),    32'(de));
        chk({tag, "_x"},    32'(x_out),     32'(x));
        chk({tag, "_y"},    32'(y_out),     32'(y));
    endtask

    initial begin
        reset = 1'b1;
        drive(K_TRC, 1'b1, HW - 1, VH - 1);
        repeat (2) @(negedge clk);
        chk("rst_de",     32'(de_out),      32'd0);
        chk("rst_x",      32'(x_out),       32'd0);
        chk("rst_y",      32'(y_out),       32'd0);
        chk("rst_data",   32'(edge_data),   32'd0);
        chk("rst_count",  32'(edge_count),  32'd0);
        chk("rst_cvalid", 32'(count_valid), 32'd0);
        reset = 1'b0;
        idle();

        test_win("uni",  K_UNI,  1'b1, 5,   9,   12'h000);
        test_win("rcol", K_RCOL, 1'b1, 100, 200, 12'h111);
        test_win("trc",  K_TRC,  1'b1, 639, 479, 12'hFFF);
        test_win("m100", K_M100, 1'b1, 1,   1,   12'h666);
        test_win("m98",  K_M98,  1'b1, 2,   2,   12'h666);
        test_win("de0",  K_TRC,  1'b0, HW - 1, VH - 1, 12'h000);
        settle(3);
        chk("no_pulse_outside_frame", 32'(pulses), 32'd0);

        // Clear the accumulator polluted by the directed windows
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;

        // Frame A: 10 edges, last one at the frame-end pixel
        p_before = pulses;
        stream(0, NPIX);
        settle(5);
        chk("A_pulses",  32'(pulses - p_before),   32'd1);
        chk("A_latency", 32'(pulse_cyc - last_cyc), 32'd3);
        chk("A_count",   32'(edge_count),          32'd10);
        chk("A_cvalid_low", 32'(count_valid),      32'd0);

        // Edge windows with de low, including the frame-end coordinate
        repeat (4) begin
            @(negedge clk);
            drive(K_TRC, 1'b0, HW - 1, VH - 1);
        end
        settle(2);
        chk("gap_data",   32'(edge_data),          32'd0);
        chk("gap_pulses", 32'(pulses - p_before),  32'd1);

        // Frame B: 3 edges, counted from zero
        p_before = pulses;
        stream(1, NPIX);
        settle(5);
        chk("B_pulses", 32'(pulses - p_before), 32'd1);
        chk("B_count",  32'(edge_count),        32'd3);

        // Frame C interrupted by a one-cycle reset
        stream(2, 6);
        @(negedge clk);
        reset = 1'b1;
        drive(K_TRC, 1'b1, 6, 0);
        @(negedge clk);
        chk("mid_rst_data",   32'(edge_data),   32'd0);
        chk("mid_rst_de",     32'(de_out),      32'd0);
        chk("mid_rst_x",      32'(x_out),       32'd0);
        chk("mid_rst_count",  32'(edge_count),  32'd0);
        chk("mid_rst_cvalid", 32'(count_valid), 32'd0);
        reset = 1'b0;
        idle();

        // Frame D: 5 edges after the reset
        p_before = pulses;
        stream(3, NPIX);
        settle(5);
        chk("D_pulses", 32'(pulses - p_before), 32'd1);
        chk("D_count",  32'(edge_count),        32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
